// File: rtl/lf_pkg.sv
// Shared definitions for the layer-0 front end: quantizer constants, the
// packed input-vector width and the quantizer control states.
package lf_pkg;

    // Default configuration of the feature stream and the quantizer.
    localparam int NUM_FEATURES_DEF = 64;
    localparam int FEAT_W_DEF       = 16;
    localparam int CNT_W_DEF        = 16;
    localparam int Q_IN_BITS        = 2;
    localparam int Q_SHIFT          = 6;
    localparam int Q_OFFSET         = 2;

    // Packed width of one quantized sample as seen by the layer-0 array.
    localparam int IN_VEC_W = NUM_FEATURES_DEF * Q_IN_BITS;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } lf_state_t;

endpackage

// File: rtl/feature_quant_clamp.sv
// Combinational uniform quantizer: arithmetic shift, signed offset, then a
// clamp into the unsigned range [0, 2^IN_BITS-1].
module feature_quant_clamp
    import lf_pkg::*;
#(
    parameter int FEAT_W  = FEAT_W_DEF,
    parameter int IN_BITS = Q_IN_BITS,
    parameter int SHIFT   = Q_SHIFT,
    parameter int OFFSET  = Q_OFFSET
) (
    input  logic signed [FEAT_W-1:0] raw,
    output logic        [IN_BITS-1:0] q
);

    // One extra bit keeps the offset addition free of overflow.
    localparam logic signed [FEAT_W:0] OFFSET_W = (FEAT_W+1)'(OFFSET);
    localparam logic signed [FEAT_W:0] Q_MAX    = (FEAT_W+1)'((1 << IN_BITS) - 1);

    function automatic logic [IN_BITS-1:0] clamp(input logic signed [FEAT_W:0] v);
        if (v[FEAT_W]) begin
            return '0;
        end else if (v > Q_MAX) begin
            return '1;
        end else begin
            return v[IN_BITS-1:0];
        end
    endfunction

    logic signed [FEAT_W-1:0] shifted;
    logic signed [FEAT_W:0]   biased;

    // Shift, sign-extend, add offset and clamp the accepted feature.
    always_comb begin
        shifted = raw >>> SHIFT;
        biased  = {shifted[FEAT_W-1], shifted} + OFFSET_W;
        q       = clamp(biased);
    end

endmodule

// File: rtl/input_feature_quantizer.sv
// Collects one raw feature per beat, quantizes it, and presents each complete
// sample as a packed word to the layer-0 neurons. Samples whose length does
// not match NUM_FEATURES are dropped with a one-cycle error pulse, and the
// stream resynchronises on the next s_last.
module input_feature_quantizer
    import lf_pkg::*;
#(
    parameter int NUM_FEATURES = NUM_FEATURES_DEF,
    parameter int FEAT_W       = FEAT_W_DEF,
    parameter int IN_BITS      = Q_IN_BITS,
    parameter int SHIFT        = Q_SHIFT,
    parameter int OFFSET       = Q_OFFSET,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FEAT_W-1:0]               s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic [NUM_FEATURES*IN_BITS-1:0] m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            err_pulse,
    output logic [CNT_W-1:0]                sample_cnt
);

    localparam int VEC_W = NUM_FEATURES * IN_BITS;
    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    lf_state_t          state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [VEC_W-1:0]   sample_buf, sample_nxt;
    logic [IN_BITS-1:0] q;
    logic               beat, store, load, handshake, err_nxt;

    feature_quant_clamp #(
        .FEAT_W  (FEAT_W),
        .IN_BITS (IN_BITS),
        .SHIFT   (SHIFT),
        .OFFSET  (OFFSET)
    ) u_quant (
        .raw (s_data),
        .q   (q)
    );

    // Input is refused while a sample is held and while reset is asserted.
    assign s_ready = (state != HOLD) && !rst;
    assign beat    = s_valid && s_ready;

    // Next-state, index and buffer-update decisions for each accepted beat.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        store      = 1'b0;
        load       = 1'b0;
        err_nxt    = 1'b0;
        handshake  = 1'b0;
        sample_nxt = sample_buf;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            if (idx == IDX_W'(i)) begin
                sample_nxt[i*IN_BITS +: IN_BITS] = q;
            end
        end
        case (state)
            COLLECT: begin
                if (beat) begin
                    if (s_last && (idx == LAST_IDX)) begin
                        load      = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = HOLD;
                    end else if (s_last) begin
                        idx_nxt = '0;
                        err_nxt = 1'b1;
                    end else if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        err_nxt   = 1'b1;
                        state_nxt = DISCARD;
                    end else begin
                        store   = 1'b1;
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            DISCARD: begin
                if (beat && s_last) begin
                    state_nxt = COLLECT;
                end
            end
            HOLD: begin
                if (m_valid && m_ready) begin
                    handshake = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt = COLLECT;
                idx_nxt   = '0;
            end
        endcase
    end

    // Control state and feature index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Partial-sample buffer; stale slots are never exposed, so no reset.
    always_ff @(posedge clk) begin
        if (store) begin
            sample_buf <= sample_nxt;
        end
    end

    // Output sample register, valid flag, error pulse and saturating count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            err_pulse  <= 1'b0;
            sample_cnt <= '0;
        end else begin
            if (load) begin
                m_data <= sample_nxt;
            end
            m_valid   <= (state_nxt == HOLD);
            err_pulse <= err_nxt;
            if (handshake && (sample_cnt != '1)) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/input_feature_quantizer.md
Name: input_feature_quantizer

Overview:
- Upstream stage of the layer-0 neuron LUT array.
- Accepts one raw signed feature per beat on a valid/ready stream and quantizes each feature uniformly to IN_BITS bits.
- Assembles a full sample into one packed input word and presents it to the layer-0 neurons with a valid/ready handshake.
- Detects malformed samples (wrong feature count) and resynchronises on the sample delimiter.

Parameters:
- NUM_FEATURES, 64: features per sample.
- FEAT_W, 16: width of a signed raw feature.
- IN_BITS, 2: quantized width per feature.
- SHIFT, 6: arithmetic right shift applied before the offset.
- OFFSET, 2: signed offset added after the shift.
- CNT_W, 16: width of the emitted-sample counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- s_data  input  FEAT_W  raw feature, two's complement.
- s_valid  input  1  s_data/s_last valid.
- s_last  input  1  marks the last feature of a sample.
- s_ready  output  1  block accepts a feature this cycle.
- m_data  output  NUM_FEATURES*IN_BITS  packed quantized sample; feature i at bits [i*IN_BITS +: IN_BITS], feature 0 = first received.
- m_valid  output  1  m_data holds a complete sample.
- m_ready  input  1  layer-0 consumer accepts.
- err_pulse  output  1  one-cycle pulse per malformed sample.
- sample_cnt  output  CNT_W  samples emitted, saturating at all-ones.

Behaviour:
- Reset (async, rst=1): state=COLLECT, feature index=0, m_data=0, m_valid=0, err_pulse=0, sample_cnt=0. s_ready is combinational and goes high only after rst deasserts.
- Quantize (combinational on the accepted beat):
  - q = (s_data >>> SHIFT) + OFFSET, computed in signed FEAT_W+1 bits so there is no overflow.
  - Clamp q to [0, 2^IN_BITS-1].
  - Example with defaults: -200 -> -4+2 = -2 -> 0; 100 -> 1+2 = 3 -> 3; 64 -> 1+2 = 3; 0 -> 2.
- A beat transfers when s_valid & s_ready. Its quantized value is written into the sample buffer slot at the current index.
- COLLECT (s_ready=1):
  - Beat with s_last=0 and index < NUM_FEATURES-1: store, index++.
  - Beat with s_last=1 and index == NUM_FEATURES-1: store, index=0, go to HOLD. m_valid rises the next cycle (one cycle from last beat to m_valid).
  - Beat with s_last=1 and index < NUM_FEATURES-1 (early last): discard the partial sample, index=0, err_pulse=1 next cycle, stay in COLLECT.
  - Beat with s_last=0 and index == NUM_FEATURES-1 (missing last): discard, index=0, err_pulse=1 next cycle, go to DISCARD.
- DISCARD (s_ready=1): consume beats without storing. On a beat with s_last=1, go to COLLECT. No further err_pulse.
- HOLD (s_ready=0):
  - m_valid=1; m_data is stable until the handshake.
  - On m_valid & m_ready: next cycle m_valid=0, sample_cnt++ (saturating), state=COLLECT.
  - No same-cycle accept of a new feature. The earliest next feature is accepted the cycle after the handshake.
- m_data is a register loaded from the sample buffer on the COLLECT->HOLD transition. Buffer slots not rewritten by a later sample are never exposed, because only complete samples are emitted.
- Throughput: NUM_FEATURES+1 cycles per sample minimum with m_ready tied high.
- rst mid-sample or mid-HOLD: everything returns to reset values immediately. The partial or held sample is lost and no err_pulse is generated.
- Input values while s_valid=0 are ignored. s_data may change freely then.
- NUM_FEATURES=1: every beat must carry s_last=1. A beat with s_last=0 is a missing last (goes to DISCARD).

Decomposition:
- Shared package lf_pkg holds:
  - the quantizer constants (SHIFT, OFFSET, IN_BITS);
  - the localparam IN_VEC_W = NUM_FEATURES*IN_BITS, so the layer-0 array and this block agree on the packed width;
  - the state enumeration {COLLECT, HOLD, DISCARD}.
- One natural sub-module: feature_quant_clamp, a purely combinational shift/offset/clamp reused for each beat.

Test Plan:
- NUM_FEATURES=4, m_ready=1, beats {100, 0, -200, 64} with last on the 4th -> one cycle later m_valid=1, m_data=8'b11_00_10_11 (feature 0 in LSBs), sample_cnt=1.
- Same sample with m_ready held 0 for 5 cycles -> s_ready=0 and m_data stable throughout; a beat presented during HOLD is not consumed; it is accepted the cycle after m_ready=1.
- 2 beats with last on the 2nd (early last) -> err_pulse=1 for exactly one cycle, no m_valid, then a correct 4-beat sample is emitted normally.
- 6 beats with last only on the 6th -> err_pulse once after beat 4, beats 5-6 swallowed, no m_valid, sample_cnt unchanged, next good sample is emitted.
- rst asserted after beat 2, then a full 4-beat sample -> m_data reflects only the post-reset sample and sample_cnt=1.
- CNT_W=2, 5 good samples -> sample_cnt reads 1, 2, 3, 3, 3.
